// File: rtl/display_mux_ndigit_pkg.sv
// Shared constants for the multiplexed seven-segment display driver:
// segment bit positions and the active-low hex glyph table.
package display_mux_ndigit_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low g..a patterns for hex digits 0-F (decimal point excluded).
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/display_mux_ndigit_seg7_encode.sv
// Combinational hex-nibble to active-low seven-segment encoder with a
// decimal point input (dp_i = 1 lights the point).
module seg7_encode
  import display_mux_ndigit_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] segments_o
);

  always_comb begin
    segments_o                = 8'hFF;
    segments_o[SEG_G:SEG_A]   = HEX_SEG_TABLE[nibble_i];
    segments_o[SEG_DP]        = ~dp_i;
  end

endmodule

// File: rtl/display_mux_ndigit.sv
// Time-multiplexed N-digit seven-segment driver with per-frame shadowing,
// ghosting blank interval, PWM brightness and leading-zero suppression.
module display_mux_ndigit
  import display_mux_ndigit_pkg::*;
#(
  parameter int NDIGITS      = 8,
  parameter int TICK_DIV     = 65536,
  parameter int BLANK_CYCLES = 256,
  parameter int PWM_BITS     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   val,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic                   lz_suppress,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [7:0]             segments,
  output logic [NDIGITS-1:0]     digitselect,
  output logic                   frame_start
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] BLANK_T   = TW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

  logic [TW-1:0]          tickCnt_q, tickCnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*NDIGITS-1:0]   val_q, val_d;
  logic [NDIGITS-1:0]     dp_q, dp_d;
  logic [NDIGITS-1:0]     digitEn_q, digitEn_d;
  logic                   lz_q, lz_d;
  logic [7:0]             segments_q, segments_d;
  logic [NDIGITS-1:0]     digitselect_q, digitselect_d;
  logic                   frameStart_q;

  logic                   frameLoad;
  logic [NDIGITS-1:0]     zeroFromHere;
  logic                   allZero;
  logic                   suppressed;
  logic [PWM_BITS-1:0]    pwmPhase;
  logic                   lit;
  logic [3:0]             curNibble;
  logic [7:0]             encSeg;

  // Slot timer, digit scan and the once-per-frame shadow capture.
  always_comb begin
    frameLoad = (tickCnt_q == '0) && (idx_q == '0);
    tickCnt_d = tickCnt_q + 1'b1;
    idx_d     = idx_q;
    if (tickCnt_q == TICK_LAST) begin
      tickCnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    val_d     = frameLoad ? val         : val_q;
    dp_d      = frameLoad ? dp          : dp_q;
    digitEn_d = frameLoad ? digit_en    : digitEn_q;
    lz_d      = frameLoad ? lz_suppress : lz_q;
  end

  // zeroFromHere[i] is set when nibble i and every more-significant nibble are zero.
  always_comb begin
    zeroFromHere = '0;
    allZero      = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      allZero         = allZero & (val_q[4*i +: 4] == 4'h0);
      zeroFromHere[i] = allZero;
    end
  end

  assign curNibble = val_q[{idx_q, 2'b00} +: 4];

  seg7_encode u_encode (
    .nibble_i   (curNibble),
    .dp_i       (dp_q[idx_q]),
    .segments_o (encSeg)
  );

  always_comb begin
    suppressed    = lz_q && (idx_q != '0) && zeroFromHere[idx_q];
    pwmPhase      = PWM_BITS'(tickCnt_q);
    lit           = (tickCnt_q >= BLANK_T) && digitEn_q[idx_q] && !suppressed
                    && (pwmPhase <= brightness);
    segments_d    = 8'hFF;
    digitselect_d = '1;
    if (lit) begin
      segments_d    = encSeg;
      digitselect_d = ~(NDIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tickCnt_q     <= '0;
      idx_q         <= '0;
      val_q         <= '0;
      dp_q          <= '0;
      digitEn_q     <= '0;
      lz_q          <= 1'b0;
      segments_q    <= 8'hFF;
      digitselect_q <= '1;
      frameStart_q  <= 1'b0;
    end else begin
      tickCnt_q     <= tickCnt_d;
      idx_q         <= idx_d;
      val_q         <= val_d;
      dp_q          <= dp_d;
      digitEn_q     <= digitEn_d;
      lz_q          <= lz_d;
      segments_q    <= segments_d;
      digitselect_q <= digitselect_d;
      frameStart_q  <= frameLoad;
    end
  end

  assign segments    = segments_q;
  assign digitselect = digitselect_q;
  assign frame_start = frameStart_q;

endmodule
